// File: rtl/pipelined_adder_pkg.sv
// Shared constants and types for the skewed carry-look-ahead pipeline.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipelined_adder_pkg;

    // Width of one carry-look-ahead group; each pipeline stage resolves one group.
    localparam int CLA_GROUP = 8;

    // Per-stage control word that travels alongside the partial sum.
    typedef struct packed {
        logic vld;     // stage holds a live operand set
        logic carry;   // carry out of the group resolved in this stage
        logic zero;    // all sum bits resolved so far are zero
    } stage_ctl_t;

    // Pipeline depth: one stage per group.
    function automatic int stages_of(input int width);
        return width / CLA_GROUP;
    endfunction

    // Carry into bit 0: subtract is a + ~b + 1, so cin is ignored there.
    function automatic logic eff_cin(input logic cin, input logic sub);
        return sub | cin;
    endfunction

endpackage

// File: rtl/cla_group8.sv
// 8-bit combinational carry-look-ahead adder group.
// Latency: 0 (purely combinational).
// Backpressure: none (no state).
// Ports: a, b    - 8-bit operands
//        c_in    - carry into bit 0
//        s       - 8-bit sum
//        c_out   - carry out of bit 7
//        c_msb_in- carry into bit 7 (used for signed overflow)
module cla_group8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c_in,
    output logic [7:0] s,
    output logic       c_out,
    output logic       c_msb_in
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       acc;
    logic       run;

    // Each carry is expanded as a flat sum of products of generate/propagate
    // terms rather than rippled, so every carry depends only on a, b and c_in.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        acc  = 1'b0;
        run  = 1'b1;
        c[0] = c_in;
        for (int i = 0; i < 8; i++) begin
            acc = 1'b0;
            run = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc = acc | (g[j] & run);
                run = run & p[j];
            end
            c[i+1] = acc | (run & c_in);
        end
        s        = p ^ c[7:0];
        c_out    = c[8];
        c_msb_in = c[7];
    end

endmodule

// File: rtl/pipelined_adder.sv
// Skewed pipelined add/subtract: one 8-bit CLA group resolved per stage.
// Latency: STAGES cycles from acceptance to out_valid; one operand set per cycle.
// Backpressure: out_valid & ~out_ready freezes every stage; in_ready = ~stall.
// Ports: clk, rst_n (async active-low); in_valid/in_ready handshake for
//        a, b, cin, sub; out_valid/out_ready handshake for s, cout, ovf, zero.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int GROUP = CLA_GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGES = stages_of(WIDTH);

    logic             stall;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign b_eff    = sub ? ~b : b;
    assign c0       = eff_cin(cin, sub);

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : stg
            // Operand bits still to be consumed shrink by one group per stage.
            localparam int RW = WIDTH - GROUP * k;

            logic [RW-1:0]          opnd_a;
            logic [RW-1:0]          opnd_b;
            logic                   in_vld;
            logic                   in_cin;
            logic                   in_zero;
            logic [GROUP-1:0]       grp_s;
            logic                   grp_c;
            logic [GROUP*(k+1)-1:0] nxt_sum;
            stage_ctl_t             ctl_q;
            logic [GROUP*(k+1)-1:0] sum_q;

            if (k == 0) begin : src
                assign opnd_a  = a;
                assign opnd_b  = b_eff;
                assign in_vld  = in_valid;
                assign in_cin  = c0;
                assign in_zero = 1'b1;
                assign nxt_sum = grp_s;
            end else begin : src
                assign opnd_a  = stg[k-1].fwd.opa_q;
                assign opnd_b  = stg[k-1].fwd.opb_q;
                assign in_vld  = stg[k-1].ctl_q.vld;
                assign in_cin  = stg[k-1].ctl_q.carry;
                assign in_zero = stg[k-1].ctl_q.zero;
                assign nxt_sum = {grp_s, stg[k-1].sum_q};
            end

            if (k == STAGES - 1) begin : tail
                logic msb_c;
                logic ovf_q;

                cla_group8 u_cla (
                    .a        (opnd_a[GROUP-1:0]),
                    .b        (opnd_b[GROUP-1:0]),
                    .c_in     (in_cin),
                    .s        (grp_s),
                    .c_out    (grp_c),
                    .c_msb_in (msb_c)
                );

                // Signed overflow only makes sense on the top group.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        ovf_q <= 1'b0;
                    end else if (!stall && in_vld) begin
                        ovf_q <= grp_c ^ msb_c;
                    end
                end
            end else begin : fwd
                logic                      msb_unused;
                logic [RW-GROUP-1:0]       opa_q;
                logic [RW-GROUP-1:0]       opb_q;

                cla_group8 u_cla (
                    .a        (opnd_a[GROUP-1:0]),
                    .b        (opnd_b[GROUP-1:0]),
                    .c_in     (in_cin),
                    .s        (grp_s),
                    .c_out    (grp_c),
                    .c_msb_in (msb_unused)
                );

                // Unconsumed upper operand bits ride along with the stage.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        opa_q <= '0;
                        opb_q <= '0;
                    end else if (!stall && in_vld) begin
                        opa_q <= opnd_a[RW-1:GROUP];
                        opb_q <= opnd_b[RW-1:GROUP];
                    end
                end
            end

            // Valid bits always advance when not stalled so bubbles drain;
            // data only loads for live sets.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ctl_q <= '0;
                    sum_q <= '0;
                end else if (!stall) begin
                    ctl_q.vld <= in_vld;
                    if (in_vld) begin
                        ctl_q.carry <= grp_c;
                        ctl_q.zero  <= in_zero & (grp_s == '0);
                        sum_q       <= nxt_sum;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = stg[STAGES-1].ctl_q.vld;
    assign s         = stg[STAGES-1].sum_q;
    assign cout      = stg[STAGES-1].ctl_q.carry;
    assign zero      = stg[STAGES-1].ctl_q.zero;
    assign ovf       = stg[STAGES-1].tail.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder at WIDTH=32.
// Latency: expects results 4 cycles after presentation when unstalled.
// Backpressure: exercises out_ready stalls and a mid-flight reset.
module tb_pipelined_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;

    pipelined_adder #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
        int          issue;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    int   stall_left = 0;
    int   stall_seen = 0;
    bit   hold_out   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_ready();
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = !hold_out;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        drive_ready();
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tcin,
                        input logic tsub, input logic [31:0] es, input logic ec,
                        input logic eo, input logic ez, input bit lat);
        int guard;
        guard = 0;
        @(negedge clk);
        drive_ready();
        in_valid = 1'b1;
        a = ta;
        b = tb;
        cin = tcin;
        sub = tsub;
        #1;
        while (!in_ready) begin
            stall_seen++;
            if (guard >= 50) begin
                chk("accept_timeout", 64'(in_ready), 64'd1);
                return;
            end
            @(negedge clk);
            drive_ready();
            #1;
            guard++;
        end
        sb.push_back('{s:es, c:ec, o:eo, z:ez, issue:cyc + 1, lat:lat});
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 100) begin
            idle();
            g++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: compares the head of the scoreboard whenever a result is taken.
    logic [35:0] held;
    bit          held_vld  = 0;
    bit          head_seen = 0;
    exp_t        e;

    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            held_vld  = 0;
            head_seen = 0;
        end else begin
            if (held_vld)
                chk("hold", {out_valid, cout, ovf, zero, s}, 64'(held));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    e = sb[0];
                    if (!head_seen && e.lat)
                        chk("latency", 64'(cyc - e.issue + 1), 64'd4);
                    head_seen = 1;
                    if (out_ready) begin
                        chk("s", 64'(s), 64'(e.s));
                        chk("cout", 64'(cout), 64'(e.c));
                        chk("ovf", 64'(ovf), 64'(e.o));
                        chk("zero", 64'(zero), 64'(e.z));
                        void'(sb.pop_front());
                        head_seen = 0;
                    end
                end
            end
            held_vld = out_valid && !out_ready;
            held     = {out_valid, cout, ovf, zero, s};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_s", 64'(s), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: a, b, cin, sub -> s, cout, ovf, zero
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1);
        send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1);
        send(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1);
        send(32'h0000_0010, 32'h0000_0010, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1);
        send(32'h00FF_FF00, 32'h0000_0100, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0, 1);
        idle();
        wait_drain();

        // Back-to-back burst, no stalls
        for (int i = 1; i <= 8; i++)
            send(32'(i), 32'(i), 1'b0, 1'b0, 32'(2 * i), 1'b0, 1'b0, 1'b0, 1);
        idle();
        wait_drain();

        // Same burst with a 3-cycle output stall mid-stream
        stall_seen = 0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 6)
                stall_left = 3;
            send(32'(i), 32'(i), 1'b0, 1'b0, 32'(2 * i), 1'b0, 1'b0, 1'b0, 0);
        end
        chk("stall_cycles", 64'(stall_seen), 64'd3);
        idle();
        wait_drain();

        // Reset with three sets in flight, one of them held at the output
        hold_out = 1;
        send(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 0);
        send(32'h0000_0002, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 0);
        send(32'h0000_0003, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0006, 1'b0, 1'b0, 1'b0, 0);
        idle();
        idle();
        #1;
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        chk("pre_rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_s", 64'(s), 64'd0);
        chk("mid_rst_cout", 64'(cout), 64'd0);
        chk("mid_rst_zero", 64'(zero), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n    = 1'b1;
        hold_out = 0;
        drive_ready();
        for (int i = 0; i < 6; i++)
            idle();
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1);
        idle();
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
